// File: rtl/frame_packetizer.sv
// Sample packetizer: buffers DATA_W-bit samples in a FIFO and emits framed
// packets (header, length, payload, checksum) with valid/ready handshaking,
// flushing of short packets when input ends, and sticky overflow reporting.
module frame_packetizer #(
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       PKT_LEN    = 16,
    parameter int unsigned       FIFO_DEPTH = 32,
    parameter logic [DATA_W-1:0] HEADER     = 'hAA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              overflow,
    output logic [15:0]       pkt_count
);

    localparam int unsigned       AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned       CW        = AW + 1;
    localparam logic [CW-1:0]     DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]     PKT_LEN_C = CW'(PKT_LEN);
    localparam logic [DATA_W-1:0] PKT_LEN_W = DATA_W'(PKT_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_LEN,
        S_PAY,
        S_CHK
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, wr_en, pop;

    logic              din_valid_q, flush_pend;
    logic              start, xfer, pay_last;
    logic [DATA_W-1:0] len, start_len, pay_cnt, acc;
    logic [DATA_W-1:0] dout_next;
    logic              last_next;

    assign full      = (count == DEPTH_C);
    assign wr_en     = din_valid && !full;
    assign xfer      = dout_valid && dout_ready;
    assign start_len = (count >= PKT_LEN_C) ? PKT_LEN_W : DATA_W'(count);
    assign pay_last  = (pay_cnt == len - DATA_W'(1));

    // FIFO storage; not reset, occupancy is tracked by the pointers
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers and occupancy; a write and a pop together leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a sample arriving while the FIFO is full is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (din_valid && full) begin
            overflow <= 1'b1;
        end
    end

    // Flush request: raised when the input stream stops, dropped once a packet
    // covering everything buffered has started or nothing is left to send
    always_ff @(posedge clk) begin
        if (rst) begin
            din_valid_q <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            din_valid_q <= din_valid;
            if ((start && count <= PKT_LEN_C) || (state == S_IDLE && count == '0)) begin
                flush_pend <= 1'b0;
            end else if (din_valid_q && !din_valid) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // State register and registered output word/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            state      <= state_next;
            dout       <= dout_next;
            dout_valid <= (state_next != S_IDLE);
            dout_last  <= last_next;
        end
    end

    // Packet length latch, payload counter, checksum accumulator, packet counter
    always_ff @(posedge clk) begin
        if (rst) begin
            len       <= '0;
            pay_cnt   <= '0;
            acc       <= '0;
            pkt_count <= '0;
        end else begin
            if (start) begin
                len <= start_len;
                acc <= '0;
            end
            if (state == S_LEN && xfer) begin
                pay_cnt <= '0;
            end
            if (state == S_PAY && xfer) begin
                pay_cnt <= pay_cnt + DATA_W'(1);
                acc     <= acc + dout;
            end
            if (state == S_CHK && xfer) begin
                pkt_count <= pkt_count + 16'd1;
            end
        end
    end

    // Next state and next output word; dout is preloaded one transfer ahead,
    // so the payload path reads the word after the current FIFO head
    always_comb begin
        state_next = state;
        dout_next  = dout;
        last_next  = dout_last;
        pop        = 1'b0;
        start      = 1'b0;
        case (state)
            S_IDLE: begin
                if (count >= PKT_LEN_C || (flush_pend && count != '0)) begin
                    start      = 1'b1;
                    state_next = S_HDR;
                    dout_next  = HEADER;
                    last_next  = 1'b0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    state_next = S_LEN;
                    dout_next  = len;
                end
            end
            S_LEN: begin
                if (xfer) begin
                    state_next = S_PAY;
                    dout_next  = mem[rd_ptr];
                end
            end
            S_PAY: begin
                if (xfer) begin
                    pop = 1'b1;
                    if (pay_last) begin
                        state_next = S_CHK;
                        dout_next  = acc + dout;
                        last_next  = 1'b1;
                    end else begin
                        dout_next = mem[rd_ptr + AW'(1)];
                    end
                end
            end
            S_CHK: begin
                if (xfer) begin
                    state_next = S_IDLE;
                    dout_next  = '0;
                    last_next  = 1'b0;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_frame_packetizer.sv
// Bench for frame_packetizer: packet-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_frame_packetizer;

    localparam int DW    = 8;
    localparam int PLEN  = 16;
    localparam int DEPTH = 32;
    localparam logic [7:0] HDR = 8'hAA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  din = '0;
    logic        dv  = 1'b0;
    logic        rdy = 1'b0;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_last;
    logic        overflow;
    logic [15:0] pkt_count;

    frame_packetizer #(
        .DATA_W(DW),
        .PKT_LEN(PLEN),
        .FIFO_DEPTH(DEPTH),
        .HEADER(HDR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(dv),
        .dout(dout),
        .dout_valid(dout_valid),
        .dout_ready(rdy),
        .dout_last(dout_last),
        .overflow(overflow),
        .pkt_count(pkt_count)
    );

    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    bit          cmp_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // The model keeps the buffered samples as a queue and, when a packet
    // starts, builds the complete packet word list; output is then an index
    // into that list advanced on each accepted transfer.
    logic [7:0] mq[$];
    logic [7:0] mpkt[$];
    int         midx;
    bit         m_active, m_flush, m_prev_dv, m_ovf;
    int         m_pcnt;
    bit         e_valid, e_last;
    logic [7:0] e_dout;

    int         m_sz, m_len;
    bit         m_xfer, m_start, m_pop, m_act0;
    logic [7:0] m_sum;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            mpkt.delete();
            m_active  = 1'b0;
            m_flush   = 1'b0;
            m_prev_dv = 1'b0;
            m_ovf     = 1'b0;
            m_pcnt    = 0;
            midx      = 0;
        end else begin
            m_sz    = mq.size();
            m_act0  = m_active;
            m_xfer  = m_active && rdy;
            m_start = 1'b0;
            m_pop   = 1'b0;
            if (!m_active) begin
                if (m_sz >= PLEN || (m_flush && m_sz > 0)) begin
                    m_start = 1'b1;
                    m_len   = (m_sz < PLEN) ? m_sz : PLEN;
                    mpkt.delete();
                    mpkt.push_back(HDR);
                    mpkt.push_back(8'(m_len));
                    m_sum = '0;
                    for (int i = 0; i < m_len; i++) begin
                        mpkt.push_back(mq[i]);
                        m_sum = m_sum + mq[i];
                    end
                    mpkt.push_back(m_sum);
                    m_active = 1'b1;
                    midx     = 0;
                end
            end else if (m_xfer) begin
                if (midx >= 2 && midx < mpkt.size() - 1) m_pop = 1'b1;
                if (midx == mpkt.size() - 1) begin
                    m_active = 1'b0;
                    m_pcnt   = (m_pcnt + 1) % 65536;
                end else begin
                    midx++;
                end
            end
            if ((m_start && m_sz <= PLEN) || (!m_act0 && m_sz == 0)) m_flush = 1'b0;
            else if (m_prev_dv && !dv) m_flush = 1'b1;
            if (dv) begin
                if (m_sz == DEPTH) m_ovf = 1'b1;
                else mq.push_back(din);
            end
            if (m_pop) void'(mq.pop_front());
            m_prev_dv = dv;
        end
        e_valid = m_active;
        e_dout  = m_active ? mpkt[midx] : 8'h00;
        e_last  = m_active && (midx == mpkt.size() - 1);
    end

    // ---------------- per-cycle compare + transfer capture ----------------
    logic [7:0] got[$];
    bit         gotl[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            check("dout_valid", int'(dout_valid), int'(e_valid));
            check("dout", int'(dout), int'(e_dout));
            check("dout_last", int'(dout_last), int'(e_last));
            check("overflow", int'(overflow), int'(m_ovf));
            check("pkt_count", int'(pkt_count), m_pcnt);
            if (dout_valid && rdy) begin
                got.push_back(dout);
                gotl.push_back(dout_last);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] ex[$];
    bit         exl[$];
    bit         vhist[$];
    int unsigned bp_k;

    task automatic cyc(input logic v, input logic [7:0] d, input logic r);
        dv  = v;
        din = d;
        rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
    endtask

    function automatic logic next_rdy(input bit toggled);
        logic r;
        if (!toggled) return 1'b1;
        r = (bp_k % 3 == 0);
        bp_k++;
        return r;
    endfunction

    task automatic drain(input int budget, input bit toggled);
        int n = 0;
        cyc(1'b0, 8'h00, next_rdy(toggled));
        while ((m_active || mq.size() != 0) && n < budget) begin
            cyc(1'b0, 8'h00, next_rdy(toggled));
            n++;
        end
        check("drain_done", int'(m_active || mq.size() != 0), 0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
    endtask

    task automatic push_pkt(input int first, input int step, input int n);
        logic [7:0] s = '0;
        logic [7:0] w;
        ex.push_back(HDR);   exl.push_back(1'b0);
        ex.push_back(8'(n)); exl.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            w = 8'(first + step * i);
            s = s + w;
            ex.push_back(w);
            exl.push_back(1'b0);
        end
        ex.push_back(s); exl.push_back(1'b1);
    endtask

    task automatic check_seq(input string name);
        check({name, "_len"}, got.size(), ex.size());
        for (int i = 0; i < ex.size() && i < got.size(); i++) begin
            check(name, int'(got[i]), int'(ex[i]));
            check({name, "_last"}, int'(gotl[i]), int'(exl[i]));
        end
    endtask

    task automatic clear_logs();
        got.delete();
        gotl.delete();
        ex.delete();
        exl.delete();
        vhist.delete();
    endtask

    int ga, gb, gc;

    // ---------------- test sequence ----------------
    initial begin
        do_reset();
        cmp_en = 1'b1;
        check("rst_dout", int'(dout), 0);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_last", int'(dout_last), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_pkts", int'(pkt_count), 0);

        // Full packet
        clear_logs();
        for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b1);
        drain(200, 1'b0);
        push_pkt(1, 1, 16);
        check_seq("full");
        if (got.size() == 19) begin
            check("full_len_word", int'(got[1]), 8'h10);
            check("full_cksum", int'(got[18]), 8'h88);
        end else check("full_size", got.size(), 19);
        check("full_pkts", int'(pkt_count), 1);

        // Partial flush
        do_reset();
        clear_logs();
        for (int i = 1; i <= 5; i++) cyc(1'b1, 8'(16 * i), 1'b1);
        drain(200, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1);
        push_pkt(8'h10, 8'h10, 5);
        check_seq("flush");
        if (got.size() == 8) check("flush_cksum", int'(got[7]), 8'hF0);
        else check("flush_size", got.size(), 8);
        check("flush_pkts", int'(pkt_count), 1);

        // Backpressure
        do_reset();
        clear_logs();
        bp_k = 0;
        for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), next_rdy(1'b1));
        drain(400, 1'b1);
        push_pkt(1, 1, 16);
        check_seq("bp");
        check("bp_pkts", int'(pkt_count), 1);

        // Overflow
        do_reset();
        clear_logs();
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, 8'(i), 1'b0);
            if (i == 32) check("ovf_before", int'(overflow), 0);
            if (i == 33) check("ovf_after", int'(overflow), 1);
        end
        drain(300, 1'b0);
        push_pkt(1, 1, 16);
        push_pkt(17, 1, 16);
        check_seq("ovf");
        check("ovf_pkts", int'(pkt_count), 2);
        check("ovf_sticky", int'(overflow), 1);

        // Back-to-back
        do_reset();
        clear_logs();
        for (int i = 0; i < 32; i++) begin
            cyc(1'b1, 8'(i), 1'b1);
            vhist.push_back(dout_valid);
        end
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            vhist.push_back(dout_valid);
        end
        push_pkt(0, 1, 16);
        push_pkt(16, 1, 16);
        check_seq("b2b");
        if (got.size() == 38) begin
            check("b2b_ck1", int'(got[18]), 8'h78);
            check("b2b_ck2", int'(got[37]), 8'h78);
        end else check("b2b_size", got.size(), 38);
        ga = -1; gb = -1; gc = -1;
        foreach (vhist[i]) begin
            if (ga < 0) begin
                if (vhist[i]) ga = i;
            end else if (gb < 0) begin
                if (!vhist[i]) gb = i;
            end else if (gc < 0) begin
                if (vhist[i]) gc = i;
            end
        end
        check("b2b_gap", (gb >= 0 && gc >= 0) ? gc - gb : -1, 1);
        check("b2b_pkts", int'(pkt_count), 2);

        // Reset mid-packet
        do_reset();
        clear_logs();
        for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b1);
        check("mid_in_pay", int'(dout_valid), 1);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        check("mid_valid", int'(dout_valid), 0);
        check("mid_pkts", int'(pkt_count), 0);
        check("mid_dout", int'(dout), 0);
        clear_logs();
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h41 + i), 1'b1);
        drain(200, 1'b0);
        push_pkt(8'h41, 1, 16);
        check_seq("mid");
        check("mid_pkts2", int'(pkt_count), 1);

        // Randomized traffic, including overflow, flushes and a mid-run reset
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            int pdv;
            int prdy;
            pdv  = $urandom_range(20, 100);
            prdy = $urandom_range(10, 100);
            if (seg == 4) do_reset();
            for (int i = 0; i < 300; i++) begin
                cyc(($urandom_range(0, 99) < pdv) ? 1'b1 : 1'b0,
                    8'($urandom_range(0, 255)),
                    ($urandom_range(0, 99) < prdy) ? 1'b1 : 1'b0);
            end
        end
        for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
